uart_tx_bit_sequencer: RTL
==========================

Name: uart_tx_bit_sequencer

Overview:
Parametrised UART transmit frame sequencer that replaces the fixed 10-bit TX bit counter. It walks one frame of start, DATA_BITS data, optional parity and 1–2 stop bits, one bit per baud_tick. It publishes the current phase and bit index to the TX shift/mux logic. It reports frame completion with a single-cycle done pulse and supports abort mid-frame.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY_EN, 0, 1 inserts one parity bit after the data bits.
STOP_BITS, 1, stop bits per frame; legal 1..2.
Any illegal value must stop elaboration.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous reset, active low.
baud_tick  input  1  one-cycle pulse marking the end of each bit period.
start  input  1  frame request; sampled only in IDLE.
abort  input  1  cancels the frame in progress.
busy  output  1  high from the cycle after an accepted start until the frame ends or aborts.
phase  output  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP; values 5–7 never driven.
bit_idx  output  4  DATA: 0..DATA_BITS-1; STOP: 0..STOP_BITS-1; otherwise 0.
bit_tick  output  1  one-cycle pulse after each consumed baud_tick.
done  output  1  one-cycle pulse after the final stop bit completes.
aborted  output  1  one-cycle pulse after an accepted abort.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, phase IDLE, internal counters 0, immediately.
  - Applies at any point, including mid-frame.
  - No done or aborted pulse is produced by reset.
- Frame length: FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS; range 7..13.
- All outputs are registered.
- IDLE:
  - start=1 and abort=0 in cycle N gives phase START and busy=1 in cycle N+1.
  - A baud_tick in cycle N is not consumed; the start bit begins at N+1.
- Advancing: a baud_tick seen while busy ends the current bit.
  - START → DATA with bit_idx 0.
  - DATA with bit_idx < DATA_BITS-1 → bit_idx+1.
  - Last DATA → PARITY if PARITY_EN, else STOP with bit_idx 0.
  - PARITY → STOP with bit_idx 0.
  - STOP with bit_idx < STOP_BITS-1 → bit_idx+1.
  - Last STOP → IDLE.
- bit_tick: asserts in the cycle the new state is visible, so it coincides with each transition above, including the last one.
- Final stop-bit tick in cycle M. In cycle M+1:
  - phase IDLE, busy 0, bit_idx 0.
  - done=1 and bit_tick=1.
  - done is low in all other cycles.
- Back-to-back frames: start is accepted in cycle M+1 (while done=1). The next frame shows START at M+2 with no idle bit inserted.
- start while busy: ignored; not queued.
- abort while busy in cycle K:
  - Cycle K+1: phase IDLE, busy 0, bit_idx 0, aborted=1.
  - No done and no bit_tick, even if baud_tick or the final stop tick falls in cycle K.
- abort in IDLE: ignored; no aborted pulse. With start in the same cycle, abort wins and start is dropped.
- Idle baud_tick: no effect.
- baud_tick wider than one cycle: each high cycle counts as one tick. Callers must pulse it.

Test Plan:
- Defaults (8,0,1): start pulse, then 10 baud_ticks spaced 16 clocks → phase 1,2×8 (bit_idx 0..7),4; bit_tick ×10; done exactly once, 1 clk after the 10th tick; busy for 10×16 clks.
- PARITY_EN=1, STOP_BITS=2, DATA_BITS=7 → 11 ticks; phase 3 after data bit_idx 6; STOP bit_idx 0 then 1; done after the 11th tick, not the 10th.
- Back-to-back: start held high through done → second frame START 1 clk after done; done twice total; start pulses during busy produce no extra frame.
- Abort at data bit 3 coincident with baud_tick → next cycle IDLE, aborted=1, done=0, bit_tick=0; subsequent start gives a clean full 10-tick frame.
- rst_n low mid-STOP → outputs 0 without a clock edge; no done after release; baud_ticks while idle cause no activity.
- Simultaneous start+abort in IDLE → stays IDLE, busy 0, no pulses; start+baud_tick same cycle → START phase still lasts until the next tick.

Source files
------------

// File: rtl/uart_tx_bit_sequencer.sv
// UART transmit frame sequencer.
// Walks one frame (start, data, optional parity, stop bits) one bit per baud_tick and
// publishes the current phase and bit index to the TX shift/mux logic. Completion is
// flagged by a one-cycle done pulse; an in-flight frame can be cancelled with abort.
module uart_tx_bit_sequencer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic [2:0] phase,
  output logic [3:0] bit_idx,
  output logic       bit_tick,
  output logic       done,
  output logic       aborted
);

  // Phase encoding seen by the TX mux; 5..7 are never produced.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  localparam int unsigned FrameBits = 1 + DATA_BITS + PARITY_EN + STOP_BITS;

  // Illegal configurations must not elaborate.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $fatal(1, "uart_tx_bit_sequencer: DATA_BITS must be 5..9");
  end
  if (PARITY_EN > 1) begin : gen_bad_parity_en
    $fatal(1, "uart_tx_bit_sequencer: PARITY_EN must be 0 or 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
    $fatal(1, "uart_tx_bit_sequencer: STOP_BITS must be 1..2");
  end
  if (FrameBits < 7 || FrameBits > 13) begin : gen_bad_frame_bits
    $fatal(1, "uart_tx_bit_sequencer: frame length must be 7..13 bits");
  end

  localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

  logic [2:0] phase_q, phase_d;
  logic [3:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       bit_tick_q, bit_tick_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  // Next-state: accept start in idle, cancel on abort, otherwise advance one bit per tick.
  always_comb begin
    phase_d    = phase_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    bit_tick_d = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (!busy_q) begin
      // A tick in the accepting cycle is not consumed; the start bit begins next cycle.
      if (start && !abort) begin
        phase_d = StStart;
        idx_d   = 4'd0;
        busy_d  = 1'b1;
      end
    end else if (abort) begin
      // Abort outranks a coincident tick, so no bit_tick/done accompanies it.
      phase_d   = StIdle;
      idx_d     = 4'd0;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end else if (baud_tick) begin
      bit_tick_d = 1'b1;
      case (phase_q)
        StStart: begin
          phase_d = StData;
          idx_d   = 4'd0;
        end
        StData: begin
          if (idx_q != LastData) begin
            idx_d = idx_q + 4'd1;
          end else if (PARITY_EN != 0) begin
            phase_d = StParity;
            idx_d   = 4'd0;
          end else begin
            phase_d = StStop;
            idx_d   = 4'd0;
          end
        end
        StParity: begin
          phase_d = StStop;
          idx_d   = 4'd0;
        end
        StStop: begin
          if (idx_q != LastStop) begin
            idx_d = idx_q + 4'd1;
          end else begin
            phase_d = StIdle;
            idx_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          // Unreachable encodings recover to idle without a done pulse.
          phase_d = StIdle;
          idx_d   = 4'd0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything without producing pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StIdle;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      bit_tick_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      bit_tick_q <= bit_tick_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign phase    = phase_q;
  assign bit_idx  = idx_q;
  assign busy     = busy_q;
  assign bit_tick = bit_tick_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule
